// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller with IDLE/RUN/DRAIN sequencing and a valid/ready divide-value handshake.
// Optional tick counter output is enabled by defining CLK_DIV_CTRL_TICK_COUNT_EN.
module clk_div_ctrl #(
  parameter int CNT_W     = 26,
  parameter int RESET_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             clk_div,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending;
  logic             pending_valid;

  logic terminal;
  logic accept;
  logic stop_low;
  logic to_idle;

  assign terminal = (counter == active_div);
  assign accept   = div_valid && div_ready;
  // A stop while the output is low needs no drain: the level is already safe.
  assign stop_low = (state == RUN) && stop && !clk_div;
  assign to_idle  = ((state == RUN) && stop && (!clk_div || terminal)) ||
                    ((state == DRAIN) && terminal);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= '0;
      clk_div       <= 1'b0;
      tick          <= 1'b0;
      div_ready     <= 1'b1;
      pending       <= '0;
      pending_valid <= 1'b0;
      active_div    <= CNT_W'(RESET_DIV);
    end else begin
      case (state)
        IDLE: begin
          counter   <= '0;
          clk_div   <= 1'b0;
          tick      <= 1'b0;
          div_ready <= 1'b1;
          if (accept)
            active_div <= div_value;
          if (start && !stop)
            state <= RUN;
        end
        default: begin
          if (stop_low) begin
            state   <= IDLE;
            counter <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
          end else if (terminal) begin
            counter <= '0;
            tick    <= 1'b1;
            if (to_idle) begin
              state   <= IDLE;
              clk_div <= 1'b0;
            end else begin
              clk_div <= ~clk_div;
            end
          end else begin
            counter <= counter + CNT_W'(1);
            tick    <= 1'b0;
            if ((state == RUN) && stop)
              state <= DRAIN;
          end

          // New divide values only take effect on a period boundary or on return to IDLE.
          if (accept) begin
            if (to_idle) begin
              active_div <= div_value;
            end else begin
              pending       <= div_value;
              pending_valid <= 1'b1;
              div_ready     <= 1'b0;
            end
          end else if (pending_valid && (terminal || to_idle)) begin
            active_div    <= pending;
            pending_valid <= 1'b0;
            div_ready     <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
  logic tick_set;
  assign tick_set = busy && terminal && !stop_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_count <= '0;
    else if ((state == IDLE) && start && !stop)
      tick_count <= '0;
    else if (tick_set)
      tick_count <= tick_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized self-checking bench for clk_div_ctrl against a cycle-level behavioural model.
module tb_clk_div_ctrl;
  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             div_valid;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             clk_div;
  logic             tick;
  logic             busy;
`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
  logic [15:0]      tick_count;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: half-period position, output level, divisor and a pending queue.
  int m_busy;
  int m_drain;
  int m_pos;
  int m_level;
  int m_tick;
  int m_div;
  int m_tc;
  int m_pend_q[$];

  clk_div_ctrl #(.CNT_W(CNT_W), .RESET_DIV(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .div_valid (div_valid),
    .div_value (div_value),
    .div_ready (div_ready),
    .clk_div   (clk_div),
    .tick      (tick),
    .busy      (busy)
`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
    ,
    .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_busy  = 0;
    m_drain = 0;
    m_pos   = 0;
    m_level = 0;
    m_tick  = 0;
    m_div   = 1;
    m_tc    = 0;
    m_pend_q.delete();
  endtask

  task automatic modelStep(input int s, input int p, input int v, input int val);
    int  accept;
    int  last_of_half;
    int  early_stop;
    int  go_idle;
    accept       = v && (m_pend_q.size() == 0);
    last_of_half = m_busy && (m_pos == m_div);
    if (!m_busy) begin
      m_pos   = 0;
      m_level = 0;
      m_tick  = 0;
      if (accept) m_div = val;
      if (s && !p) begin
        m_busy  = 1;
        m_drain = 0;
        m_tc    = 0;
      end
    end else begin
      early_stop = !m_drain && p && (m_level == 0);
      go_idle    = (!m_drain && p && (m_level == 0 || last_of_half)) || (m_drain && last_of_half);
      m_tick     = last_of_half && !early_stop;
      if (m_tick) m_tc = (m_tc + 1) % 65536;
      if (early_stop) m_level = 0;
      else if (last_of_half) m_level = go_idle ? 0 : 1 - m_level;
      m_pos = (last_of_half || go_idle) ? 0 : m_pos + 1;
      if (accept) begin
        if (go_idle) m_div = val;
        else m_pend_q.push_back(val);
      end else if (m_pend_q.size() != 0 && (last_of_half || go_idle)) begin
        m_div = m_pend_q.pop_front();
      end
      if (go_idle) begin
        m_busy  = 0;
        m_drain = 0;
      end else if (p) begin
        m_drain = 1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("clk_div", clk_div, m_level);
    checkOutput("tick", tick, m_tick);
    checkOutput("busy", busy, m_busy);
    checkOutput("div_ready", div_ready, m_pend_q.size() == 0);
`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
    checkOutput("tick_count", tick_count, m_tc);
`endif
  endtask

  task automatic applyStimulus(input int s, input int p, input int v, input int val);
    start     = s[0];
    stop      = p[0];
    div_valid = v[0];
    div_value = CNT_W'(val);
    modelStep(s, p, v, val);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  // Reset lands between clock edges to exercise the asynchronous path.
  task automatic doReset();
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    compareAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0; stop = 1'b0; div_valid = 1'b0; div_value = '0;
    compareAll();
  endtask

  task automatic measureHalf(output int len);
    logic prev;
    int   n;
    n    = 0;
    prev = clk_div;
    while (clk_div == prev && n < 100) begin
      applyStimulus(0, 0, 0, 0);
      n++;
    end
    prev = clk_div;
    len  = 0;
    while (clk_div == prev && len < 100) begin
      applyStimulus(0, 0, 0, 0);
      len++;
    end
  endtask

  initial begin
    int len;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; div_valid = 1'b0; div_value = '0;
    modelReset();
    #1;
    doReset();

    // Reset divisor of 1: half-periods of 2 cycles.
    applyStimulus(1, 0, 0, 0);
    measureHalf(len);
    checkOutput("half_len_div1", len, 2);

    // Divisor 4 accepted in IDLE, then mid-run change to 2.
    doReset();
    applyStimulus(0, 0, 1, 4);
    applyStimulus(1, 0, 0, 0);
    measureHalf(len);
    checkOutput("half_len_div4", len, 5);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2);
    measureHalf(len);
    checkOutput("half_len_after_change", len, 3);
    measureHalf(len);
    checkOutput("half_len_after_change2", len, 3);

    // Stop with output high drains, stop with output low returns at once.
    for (int i = 0; i < 12; i++) applyStimulus(0, i[0], 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, (i == 3) ? 1 : 0, 0, 0);

    // Mid-period reset then idle with no ticks.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5));
    end

`ifdef CLK_DIV_CTRL_TICK_COUNT_EN
    doReset();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 65537; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("tick_count_wrap", tick_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
